// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - 8-way round-robin arbiter with hold timeout and 8:1 data selector
module rr_arbiter8 #(
  parameter int DW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      req,
  input  logic [8*DW-1:0] req_data,
  input  logic            done,
  output logic [7:0]      grant,
  output logic [2:0]      grant_idx,
  output logic            grant_valid,
  output logic [DW-1:0]   out_data,
  output logic            timeout_flag
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);
  localparam logic       TO_EN  = (TIMEOUT != 0);

  state_t     state, state_d;
  logic [2:0] ptr, ptr_d;
  logic [7:0] cnt, cnt_d;
  logic [7:0] grant_d;
  logic [2:0] grant_idx_d;
  logic       grant_valid_d;
  logic       timeout_flag_d;

  logic       any_req;
  logic [2:0] winner;
  logic       exit_done;
  logic       exit_drop;
  logic       exit_to;
  logic       exit_any;

  assign any_req   = |req;
  assign exit_done = done;
  assign exit_drop = ~req[grant_idx];
  assign exit_to   = TO_EN && (cnt == TO_LIM);
  assign exit_any  = exit_done | exit_drop | exit_to;

  // Priority search: rotate requests so index 0 is ptr, take the first set bit.
  always_comb begin
    logic [15:0] dbl;
    logic [7:0]  rot;
    logic        found;
    dbl    = {req, req} >> ptr;
    rot    = dbl[7:0];
    found  = 1'b0;
    winner = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (!found && rot[k]) begin
        found  = 1'b1;
        winner = ptr + 3'(k);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = any_req ? GRANT : IDLE;
      GRANT:   state_d = exit_any ? RELEASE : GRANT;
      RELEASE: state_d = any_req ? GRANT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of pointer, hold counter and registered grant outputs.
  always_comb begin
    ptr_d          = ptr;
    cnt_d          = cnt;
    grant_d        = grant;
    grant_idx_d    = grant_idx;
    grant_valid_d  = grant_valid;
    timeout_flag_d = 1'b0;
    case (state)
      IDLE, RELEASE: begin
        if (any_req) begin
          grant_idx_d   = winner;
          grant_d       = 8'd1 << winner;
          grant_valid_d = 1'b1;
          cnt_d         = 8'd1;
        end else begin
          grant_idx_d   = 3'd0;
          grant_d       = 8'd0;
          grant_valid_d = 1'b0;
        end
      end
      GRANT: begin
        if (exit_any) begin
          ptr_d          = grant_idx + 3'd1;
          grant_d        = 8'd0;
          grant_idx_d    = 3'd0;
          grant_valid_d  = 1'b0;
          cnt_d          = 8'd0;
          // Flag only when the timeout is the sole reason the grant ended.
          timeout_flag_d = exit_to & ~exit_done & ~exit_drop;
        end else begin
          cnt_d = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
        end
      end
      default: begin
        grant_d       = 8'd0;
        grant_idx_d   = 3'd0;
        grant_valid_d = 1'b0;
      end
    endcase
  end

  // Registered datapath and outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr          <= 3'd0;
      cnt          <= 8'd0;
      grant        <= 8'd0;
      grant_idx    <= 3'd0;
      grant_valid  <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      ptr          <= ptr_d;
      cnt          <= cnt_d;
      grant        <= grant_d;
      grant_idx    <= grant_idx_d;
      grant_valid  <= grant_valid_d;
      timeout_flag <= timeout_flag_d;
    end
  end

  // 8:1 selector routing the granted requester's word; zero when idle.
  always_comb begin
    out_data = '0;
    for (int i = 0; i < 8; i++) begin
      if (grant_valid && grant_idx == 3'(i)) begin
        out_data = req_data[i*DW +: DW];
      end
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb/tb_rr_arbiter8.sv - directed scoreboard bench for rr_arbiter8
module tb_rr_arbiter8;

  logic        clk;
  logic        rst;
  logic [7:0]  req;
  logic [63:0] req_data;
  logic        done;
  logic [7:0]  grant;
  logic [2:0]  grant_idx;
  logic        grant_valid;
  logic [7:0]  out_data;
  logic        timeout_flag;

  int total;
  int bad;
  int exp_q[$];

  rr_arbiter8 #(.DW(8), .TIMEOUT(15)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_data(req_data),
    .done(done),
    .grant(grant),
    .grant_idx(grant_idx),
    .grant_valid(grant_valid),
    .out_data(out_data),
    .timeout_flag(timeout_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input int idx);
    logic [63:0] d;
    d = req_data >> (idx * 8);
    return d[7:0];
  endfunction

  // Waits (bounded) for grant_valid, pops the expected winner and checks it.
  task automatic await_grant(input string tag, output int waited);
    int e;
    waited = 0;
    while (!grant_valid && waited < 20) begin
      tick();
      waited++;
    end
    check({tag, "_valid"}, 64'(grant_valid), 64'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd1, 64'd0);
      e = 0;
    end else begin
      e = exp_q.pop_front();
    end
    check({tag, "_idx"}, 64'(grant_idx), 64'(e));
    check({tag, "_onehot"}, 64'(grant), 64'(8'd1 << e));
    check({tag, "_data"}, 64'(out_data), 64'(byte_of(e)));
  endtask

  initial begin
    int n;
    int cyc;
    int pulses;
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    req      = 8'h00;
    done     = 1'b0;
    req_data = 64'h77_66_55_44_A5_22_11_00;
    tick();
    tick();
    rst = 1'b0;

    // Idle with no requests.
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_valid", 64'(grant_valid), 64'd0);
      check("idle_grant", 64'(grant), 64'd0);
      check("idle_idx", 64'(grant_idx), 64'd0);
      check("idle_data", 64'(out_data), 64'd0);
      check("idle_tf", 64'(timeout_flag), 64'd0);
    end

    // Rotation with done pulsed each grant: 2, 5, 7, 2.
    req = 8'b1010_0100;
    exp_q.push_back(2);
    exp_q.push_back(5);
    exp_q.push_back(7);
    exp_q.push_back(2);
    for (int g = 0; g < 4; g++) begin
      await_grant("rot", n);
      check("rot_gap", 64'(n), 64'd1);
      done = 1'b1;
      tick();
      done = 1'b0;
      check("rot_release", 64'(grant_valid), 64'd0);
      check("rot_no_tf", 64'(timeout_flag), 64'd0);
    end
    req = 8'h00;
    tick();

    // Timeout on a single requester holding without done.
    req = 8'h08;
    exp_q.push_back(3);
    await_grant("to", n);
    cyc    = 0;
    pulses = 0;
    while (grant_valid && cyc < 40) begin
      cyc++;
      check("to_data", 64'(out_data), 64'hA5);
      tick();
      if (timeout_flag) pulses++;
    end
    check("to_len", 64'(cyc), 64'd15);
    check("to_flag", 64'(timeout_flag), 64'd1);
    exp_q.push_back(3);
    tick();
    if (timeout_flag) pulses++;
    check("to_pulses", 64'(pulses), 64'd1);
    await_grant("to_regrant", n);
    check("to_regrant_gap", 64'(n), 64'd0);
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 8'h00;
    tick();

    // Pointer wrap: after 7 ends, 0 wins over 7.
    req = 8'h80;
    exp_q.push_back(7);
    await_grant("wrap7", n);
    req  = 8'h81;
    done = 1'b1;
    tick();
    done = 1'b0;
    exp_q.push_back(0);
    await_grant("wrap0", n);
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 8'h00;
    tick();

    // done coincides with the timeout at count 15: no flag.
    req = 8'h02;
    exp_q.push_back(1);
    await_grant("coinc", n);
    for (int i = 0; i < 14; i++) begin
      tick();
      check("coinc_hold", 64'(grant_valid), 64'd1);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    check("coinc_release", 64'(grant_valid), 64'd0);
    check("coinc_no_tf", 64'(timeout_flag), 64'd0);
    req = 8'h00;
    tick();

    // Requester drops at cycle 4: grant ends, no flag.
    req = 8'h04;
    exp_q.push_back(2);
    await_grant("drop", n);
    tick();
    tick();
    tick();
    check("drop_hold", 64'(grant_valid), 64'd1);
    req = 8'h00;
    tick();
    check("drop_release", 64'(grant_valid), 64'd0);
    check("drop_no_tf", 64'(timeout_flag), 64'd0);
    tick();

    // Asynchronous reset in the middle of a grant to 6.
    req = 8'h40;
    exp_q.push_back(6);
    await_grant("rst6", n);
    #2;
    rst = 1'b1;
    #1;
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_valid", 64'(grant_valid), 64'd0);
    check("rst_idx", 64'(grant_idx), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    req = 8'h41;
    tick();
    tick();
    rst = 1'b0;
    exp_q.push_back(0);
    await_grant("post_rst", n);
    check("post_rst_lat", 64'(n), 64'd1);
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
